// File: rtl/layer_mac_engine_if.sv
// Weight/bias RAM and activation RAM port bundle for layer_mac_engine.
// master = engine side, slave = RAM side.
interface layer_mac_engine_if;
  logic [9:0]  W_Address [19:0];
  logic [15:0] W_Q       [19:0];
  logic [9:0]  IO_Address;
  logic        IO_Wren;
  logic [15:0] IO_D;
  logic [15:0] IO_Q;

  modport master (
    output W_Address,
    output IO_Address,
    output IO_Wren,
    output IO_D,
    input  W_Q,
    input  IO_Q
  );

  modport slave (
    input  W_Address,
    input  IO_Address,
    input  IO_Wren,
    input  IO_D,
    output W_Q,
    output IO_Q
  );
endinterface

// File: rtl/layer_mac_engine.sv
// Twenty-lane fixed-point MAC for one fully connected layer pass:
// fetch inputs/weights, accumulate, bias, round, saturate, write back.
module layer_mac_engine #(
  parameter int N_IN     = 784,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 784,
  parameter int RD_LAT   = 2,
  parameter int FRAC     = 8,
  parameter int RELU     = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Busy,
  output logic Done,
  layer_mac_engine_if.master ram
);

  localparam int LANES = 20;
  localparam logic [9:0] K_LAST = 10'(N_IN);
  localparam logic [9:0] D_LAST = 10'(RD_LAT - 1);
  localparam logic [9:0] W_LAST = 10'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, FINAL, WRITE, DONE
  } state_e;

  state_e state_q, state_d;
  logic [9:0] cnt_q, cnt_d;

  logic vld_q  [RD_LAT];
  logic bias_q [RD_LAT];

  logic signed [41:0] acc_q [LANES];
  logic signed [41:0] acc_d [LANES];
  logic signed [41:0] term  [LANES];
  logic signed [31:0] prod  [LANES];
  logic [15:0] res_q [LANES];
  logic [15:0] res_d [LANES];

  logic issue;
  logic clr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        if (cnt_q == K_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == D_LAST) begin
          state_d = FINAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      FINAL: begin
        state_d = WRITE;
        cnt_d   = '0;
      end
      WRITE: begin
        if (cnt_q == W_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign issue = (state_q == FETCH);
  assign clr   = (state_q == IDLE) && Start;

  // Floor shift, clamp to int16, then optional ReLU
  function automatic logic [15:0] finalize(
    input logic signed [41:0] a
  );
    logic signed [41:0] s;
    logic [15:0] r;
    s = a >>> FRAC;
    if (s > 42'sd32767)
      r = 16'h7fff;
    else if (s < -42'sd32768)
      r = 16'h8000;
    else
      r = s[15:0];
    if (RELU != 0 && r[15])
      r = '0;
    return r;
  endfunction

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      prod[j] =
        $signed({{16{ram.W_Q[j][15]}}, ram.W_Q[j]}) *
        $signed({{16{ram.IO_Q[15]}}, ram.IO_Q});
      if (bias_q[RD_LAT-1])
        term[j] =
          $signed({{26{ram.W_Q[j][15]}}, ram.W_Q[j]})
          <<< FRAC;
      else
        term[j] = {{10{prod[j][31]}}, prod[j]};
      acc_d[j] = acc_q[j];
      if (clr)
        acc_d[j] = '0;
      else if (vld_q[RD_LAT-1])
        acc_d[j] = acc_q[j] + term[j];
      res_d[j] = res_q[j];
      if (state_q == FINAL)
        res_d[j] = finalize(acc_q[j]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        bias_q[i] <= 1'b0;
      end
      for (int j = 0; j < LANES; j++) begin
        acc_q[j] <= '0;
        res_q[j] <= '0;
      end
    end else begin
      vld_q[0]  <= issue;
      bias_q[0] <= issue && (cnt_q == K_LAST);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        bias_q[i] <= bias_q[i-1];
      end
      for (int j = 0; j < LANES; j++) begin
        acc_q[j] <= acc_d[j];
        res_q[j] <= res_d[j];
      end
    end
  end

  always_comb begin
    Busy           = (state_q != IDLE);
    Done           = (state_q == DONE);
    ram.IO_Wren    = (state_q == WRITE);
    ram.IO_Address = '0;
    ram.IO_D       = '0;
    for (int j = 0; j < LANES; j++)
      ram.W_Address[j] = '0;
    case (state_q)
      FETCH: begin
        ram.IO_Address = 10'(IN_BASE) + cnt_q;
        for (int j = 0; j < LANES; j++)
          ram.W_Address[j] = cnt_q;
      end
      WRITE: begin
        ram.IO_Address = 10'(OUT_BASE) + cnt_q;
        ram.IO_D       = res_q[cnt_q[4:0]];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_layer_mac_engine.sv
// Directed bench: two engines (RELU=1 and RELU=0) on shared stimulus,
// N_IN=4, RD_LAT=2, FRAC=8, IN_BASE=0, OUT_BASE=4.
module tb_layer_mac_engine;

  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  logic Busy1, Done1, Busy0, Done0;

  layer_mac_engine_if r1 ();
  layer_mac_engine_if r0 ();

  layer_mac_engine #(
    .N_IN(4), .IN_BASE(0), .OUT_BASE(4),
    .RD_LAT(2), .FRAC(8), .RELU(1)
  ) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Busy(Busy1), .Done(Done1), .ram(r1)
  );

  layer_mac_engine #(
    .N_IN(4), .IN_BASE(0), .OUT_BASE(4),
    .RD_LAT(2), .FRAC(8), .RELU(0)
  ) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Busy(Busy0), .Done(Done0), .ram(r0)
  );

  always #5 Clk = ~Clk;

  logic [15:0] wmem [20][5];
  logic [15:0] imem [4];
  logic [9:0]  wa1 [20];
  logic [9:0]  wa0 [20];
  logic [9:0]  ia1, ia0;

  function automatic int widx(input logic [9:0] a);
    return (a > 10'd4) ? 0 : int'(a);
  endfunction

  // Two-stage read pipeline: address reg, then data reg
  always @(posedge Clk) begin
    for (int j = 0; j < 20; j++) begin
      wa1[j] <= r1.W_Address[j];
      wa0[j] <= r0.W_Address[j];
      r1.W_Q[j] <= wmem[j][widx(wa1[j])];
      r0.W_Q[j] <= wmem[j][widx(wa0[j])];
    end
    ia1 <= r1.IO_Address;
    ia0 <= r0.IO_Address;
    r1.IO_Q <= imem[ia1[1:0]];
    r0.IO_Q <= imem[ia0[1:0]];
  end

  int wc1, wc0, dc1, dc0, ecnt, dedge1;
  logic [15:0] od1 [20];
  logic [15:0] od0 [20];

  always @(posedge Clk) begin
    ecnt <= ecnt + 1;
    if (Done1) begin
      dc1    <= dc1 + 1;
      dedge1 <= ecnt + 1;
    end
    if (Done0) dc0 <= dc0 + 1;
    if (r1.IO_Wren) begin
      wc1 <= wc1 + 1;
      if (r1.IO_Address >= 10'd4 && r1.IO_Address < 10'd24)
        od1[int'(r1.IO_Address) - 4] <= r1.IO_D;
    end
    if (r0.IO_Wren) begin
      wc0 <= wc0 + 1;
      if (r0.IO_Address >= 10'd4 && r0.IO_Address < 10'd24)
        od0[int'(r0.IO_Address) - 4] <= r0.IO_D;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] inp,
                      input logic [15:0] w0,
                      input logic [15:0] step,
                      input logic [15:0] bias);
    for (int k = 0; k < 4; k++) imem[k] = inp;
    for (int j = 0; j < 20; j++) begin
      for (int k = 0; k < 4; k++)
        wmem[j][k] = 16'(w0 + 16'(j) * step);
      wmem[j][4] = bias;
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (dc1 < target && n < 200) begin
      @(negedge Clk);
      n++;
    end
  endtask

  task automatic chk_data(input string tag,
                          input logic [15:0] b1,
                          input logic [15:0] s1,
                          input logic [15:0] b0v);
    for (int j = 0; j < 20; j++) begin
      chk($sformatf("%s relu1 lane%0d", tag, j),
          32'(od1[j]), 32'(16'(b1 + 16'(j) * s1)));
      chk($sformatf("%s relu0 lane%0d", tag, j),
          32'(od0[j]), 32'(16'(b0v + 16'(j) * s1)));
    end
  endtask

  // One Start pulse, optional stray Start during DRAIN, then checks
  task automatic run_pass(input string tag,
                          input logic [15:0] b1,
                          input logic [15:0] s1,
                          input logic [15:0] b0v,
                          input bit drain_pulse);
    int bw1, bw0, bd, bd0, t0;
    bw1 = wc1; bw0 = wc0; bd = dc1; bd0 = dc0;
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    t0 = ecnt;
    if (drain_pulse) begin
      repeat (5) @(negedge Clk);
      chk({tag, " busy in drain"}, 32'(Busy1), 32'd1);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
    end
    wait_done(bd + 1);
    chk({tag, " done seen"}, 32'(dc1 - bd), 32'd1);
    chk({tag, " done latency"}, 32'(dedge1 - t0), 32'd29);
    chk({tag, " idle after done"}, 32'(Busy1), 32'd0);
    chk({tag, " writes relu1"}, 32'(wc1 - bw1), 32'd20);
    chk({tag, " writes relu0"}, 32'(wc0 - bw0), 32'd20);
    chk_data(tag, b1, s1, b0v);
    repeat (40) @(negedge Clk);
    chk({tag, " single done"}, 32'(dc1 - bd), 32'd1);
    chk({tag, " single done r0"}, 32'(dc0 - bd0), 32'd1);
    chk({tag, " no extra writes"}, 32'(wc1 - bw1), 32'd20);
  endtask

  initial begin
    int bw, bd, t0, d1;
    Reset = 1'b1;
    Start = 1'b0;
    load(16'h0100, 16'h0000, 16'h0100, 16'h0080);
    repeat (3) @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    chk("reset busy", 32'(Busy1), 32'd0);
    chk("reset busy r0", 32'(Busy0), 32'd0);
    chk("reset done", 32'(Done1), 32'd0);
    chk("reset wren", 32'(r1.IO_Wren), 32'd0);
    chk("reset io addr", 32'(r1.IO_Address), 32'd0);
    chk("reset io d", 32'(r1.IO_D), 32'd0);
    chk("reset w addr0", 32'(r1.W_Address[0]), 32'd0);
    chk("reset w addr19", 32'(r1.W_Address[19]), 32'd0);
    Start = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    chk("idle after reset", 32'(Busy1), 32'd0);

    run_pass("normal", 16'h0080, 16'h0400, 16'h0080, 1'b0);

    load(16'h0100, 16'hff00, 16'h0000, 16'h0000);
    run_pass("relu", 16'h0000, 16'h0000, 16'hfc00, 1'b0);

    load(16'h7fff, 16'h7fff, 16'h0000, 16'h7fff);
    run_pass("sat pos", 16'h7fff, 16'h0000, 16'h7fff, 1'b0);

    load(16'h7fff, 16'h8000, 16'h0000, 16'h0000);
    run_pass("sat neg", 16'h0000, 16'h0000, 16'h8000, 1'b0);

    // Reset during FETCH k=2
    load(16'h0100, 16'h0000, 16'h0100, 16'h0080);
    bw = wc1; bd = dc1;
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    chk("fetch k2 addr", 32'(r1.IO_Address), 32'd2);
    chk("fetch k2 waddr", 32'(r1.W_Address[7]), 32'd2);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst fetch busy", 32'(Busy1), 32'd0);
    chk("rst fetch wren", 32'(r1.IO_Wren), 32'd0);
    repeat (40) @(negedge Clk);
    chk("rst fetch no done", 32'(dc1 - bd), 32'd0);
    chk("rst fetch no writes", 32'(wc1 - bw), 32'd0);

    // Reset during WRITE j=5
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (13) @(negedge Clk);
    chk("write j5 wren", 32'(r1.IO_Wren), 32'd1);
    chk("write j5 addr", 32'(r1.IO_Address), 32'd9);
    chk("write j5 data", 32'(r1.IO_D), 32'h1480);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst write busy", 32'(Busy1), 32'd0);
    chk("rst write wren", 32'(r1.IO_Wren), 32'd0);
    repeat (40) @(negedge Clk);
    chk("rst write no done", 32'(dc1 - bd), 32'd0);
    chk("rst write count", 32'(wc1 - bw), 32'd6);

    run_pass("after reset", 16'h0080, 16'h0400, 16'h0080, 1'b0);
    run_pass("drain start", 16'h0080, 16'h0400, 16'h0080, 1'b1);

    // Start held high across two passes
    load(16'h0100, 16'hff00, 16'h0000, 16'h0000);
    bw = wc1; bd = dc1;
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    t0 = ecnt;
    wait_done(bd + 1);
    d1 = dedge1;
    chk("hold first done", 32'(dc1 - bd), 32'd1);
    chk("hold first latency", 32'(d1 - t0), 32'd29);
    chk("hold idle gap", 32'(Busy1), 32'd0);
    @(negedge Clk);
    chk("hold restart", 32'(Busy1), 32'd1);
    Start = 1'b0;
    wait_done(bd + 2);
    chk("hold second done", 32'(dc1 - bd), 32'd2);
    chk("hold second spacing", 32'(dedge1 - d1), 32'd30);
    chk("hold writes", 32'(wc1 - bw), 32'd40);
    chk_data("hold", 16'h0000, 16'h0000, 16'hfc00);
    repeat (40) @(negedge Clk);
    chk("hold no third", 32'(dc1 - bd), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
